// File: rtl/mem_rmw_ctrl.sv
// mem_rmw_ctrl: byte/half/word load-store controller for a word-only RAM, sub-word stores via read-modify-write.
// Optional MEM_PERF_CNT_EN adds cnt_load/cnt_store/cnt_rmw counters.
module mem_rmw_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              ready,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
`ifdef MEM_PERF_CNT_EN
    output logic [31:0]       cnt_load,
    output logic [31:0]       cnt_store,
    output logic [31:0]       cnt_rmw,
`endif
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [2:0] {IDLE, RD, MERGE_WR, WR, DONE} state_t;
    state_t      state;
    logic        r_we, r_sgn, r_err;
    logic [1:0]  r_size, r_off;
    logic [15:0] r_wdata;
    logic [31:0] r_data;
    logic        req_err;
    logic [4:0]  sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext, mask, ins, merged;
    logic        unused_ok;
    assign unused_ok = ^req_addr[31:ADDR_W+2];
    assign req_err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    // Big-endian lanes: byte offset 0 lives in [31:24]
    always_comb begin
        sh     = {~r_off, 3'b000};
        lane_b = 8'(ram_rdata >> sh);
        lane_h = r_off[1] ? ram_rdata[15:0] : ram_rdata[31:16];
        ext    = r_size == 2'b00 ? {{24{r_sgn & lane_b[7]}}, lane_b} :
                 r_size == 2'b01 ? {{16{r_sgn & lane_h[15]}}, lane_h} : ram_rdata;
        mask   = r_size == 2'b00 ? 32'h0000_00FF << sh : (r_off[1] ? 32'h0000_FFFF : 32'hFFFF_0000);
        ins    = r_size == 2'b00 ? {24'b0, r_wdata[7:0]} << sh :
                 (r_off[1] ? {16'b0, r_wdata} : {r_wdata, 16'b0});
        merged = (ram_rdata & ~mask) | ins;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ready      <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            r_we       <= 1'b0;
            r_sgn      <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= '0;
            r_off      <= '0;
            r_wdata    <= '0;
            r_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req) begin
                        ready    <= 1'b0;
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_sgn    <= req_signed;
                        r_off    <= req_addr[1:0];
                        r_wdata  <= req_wdata[15:0];
                        r_err    <= req_err;
                        r_data   <= '0;
                        ram_addr <= req_addr[ADDR_W+1:2];
                        if (req_err) begin
                            state <= DONE;
                        end else if (req_we && req_size == 2'b10) begin
                            state     <= WR;
                            ram_ce    <= 1'b1;
                            ram_we    <= 1'b1;
                            ram_wdata <= req_wdata;
                        end else begin
                            state  <= RD;
                            ram_ce <= 1'b1;
                            ram_we <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (r_we) begin
                        state     <= MERGE_WR;
                        ram_we    <= 1'b1;
                        ram_wdata <= merged;
                    end else begin
                        state  <= DONE;
                        ram_ce <= 1'b0;
                        r_data <= ext;
                    end
                end
                MERGE_WR, WR: begin
                    state  <= DONE;
                    ram_ce <= 1'b0;
                    ram_we <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    ready      <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_err   <= r_err;
                    resp_rdata <= r_data;
                end
            endcase
        end
    end
`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_load  <= '0;
            cnt_store <= '0;
            cnt_rmw   <= '0;
        end else begin
            if (state == DONE && !r_err && !r_we) cnt_load <= cnt_load + 32'd1;
            if (state == DONE && !r_err && r_we) cnt_store <= cnt_store + 32'd1;
            if (state == RD && r_we) cnt_rmw <= cnt_rmw + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// tb_mem_rmw_ctrl: directed test of mem_rmw_ctrl against a small behavioural RAM.
module tb_mem_rmw_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        ready, resp_valid, resp_err, ram_ce, ram_we;
    logic [31:0] resp_rdata, ram_wdata, ram_rdata;
    logic [16:0] ram_addr;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] cnt_load, cnt_store, cnt_rmw;
`endif
    logic [31:0] mem [0:15];
    int checks = 0, failures = 0;
    int ce_cnt = 0, cyc = 0, nacc = 0;
    int acc [0:7];
    int lat;
    logic err;
    logic [31:0] rd;

    mem_rmw_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .ready(ready), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef MEM_PERF_CNT_EN
        .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_rmw(cnt_rmw),
`endif
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    assign ram_rdata = mem[ram_addr[3:0]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_ce) ce_cnt <= ce_cnt + 1;
        if (ram_ce && ram_we) mem[ram_addr[3:0]] <= ram_wdata;
        if (req && ready && nacc < 8) begin
            acc[nacc] <= cyc;
            nacc <= nacc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, output int l, output logic e, output logic [31:0] r);
        int t;
        @(negedge clk);
        req = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        t = 0;
        while (!ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 req = 1'b0;
        l = -1;
        for (int i = 1; i <= 8 && l < 0; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) l = i;
        end
        e = resp_err;
        r = resp_rdata;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        #12;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_ce_we", {30'b0, ram_ce, ram_we}, 32'd0);
        check("rst_addr", {15'b0, ram_addr}, 32'd0);
        check("rst_wdata", ram_wdata, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk) rst = 1'b1;

        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, rd);
        check("sw_lat", lat, 32'd2);
        check("sw_addr", {15'b0, ram_addr}, 32'd4);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        check("sw_rdata", rd, 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, rd);
        check("lw_lat", lat, 32'd2);
        check("lw_data", rd, 32'hDEADBEEF);
        check("lw_err", {31'b0, err}, 32'd0);

        mem[4] = 32'h11223344;
        access(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAA, lat, err, rd);
        check("sb_lat", lat, 32'd3);
        check("sb_mem", mem[4], 32'h11AA3344);

        mem[4] = 32'h80FF7F01;
        access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat, err, rd);
        check("lb", rd, 32'hFFFFFF80);
        check("lb_lat", lat, 32'd2);
        access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, err, rd);
        check("lbu", rd, 32'h00000080);
        access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, err, rd);
        check("lb3", rd, 32'h00000001);
        access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, err, rd);
        check("lh2", rd, 32'h00007F01);
        access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, err, rd);
        check("lh0", rd, 32'hFFFF80FF);
        access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, err, rd);
        check("lhu0", rd, 32'h000080FF);

        begin
            int ce0;
            ce0 = ce_cnt;
            access(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, err, rd);
            check("lw_mis_err", {31'b0, err}, 32'd1);
            check("lw_mis_rdata", rd, 32'd0);
            check("lw_mis_lat", lat, 32'd1);
            access(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, lat, err, rd);
            check("sh_mis_err", {31'b0, err}, 32'd1);
            check("sh_mis_lat", lat, 32'd1);
            access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, err, rd);
            check("rsv_err", {31'b0, err}, 32'd1);
            check("err_no_ce", ce_cnt, ce0);
            check("err_mem", mem[4], 32'h80FF7F01);
        end

        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_addr = 32'h12; req_wdata = 32'hBEEF;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1 check("mw_we", {30'b0, ram_ce, ram_we}, 32'd3);
        rst = 1'b0;
        #1;
        check("ar_ready", {31'b0, ready}, 32'd1);
        check("ar_ce_we", {30'b0, ram_ce, ram_we}, 32'd0);
        check("ar_addr", {15'b0, ram_addr}, 32'd0);
        check("ar_wdata", ram_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        check("ar_mem", mem[4], 32'h80FF7F01);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, rd);
        check("ar_lw", rd, 32'h80FF7F01);
        check("ar_lat", lat, 32'd2);

        mem[8] = 32'h0;
        mem[9] = 32'hAABBCCDD;
        @(negedge clk);
        nacc = 0;
        for (int k = 0; k < 3; k++) begin
            int t;
            req = 1'b1; req_we = 1'b1; req_signed = 1'b0;
            req_size  = k == 0 ? 2'b10 : k == 1 ? 2'b00 : 2'b01;
            req_addr  = k == 0 ? 32'h20 : k == 1 ? 32'h21 : 32'h26;
            req_wdata = k == 0 ? 32'h00000001 : k == 1 ? 32'h00000022 : 32'h00003344;
            t = 0;
            while (!ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("b2b_nacc", nacc, 32'd3);
        check("b2b_gap1", acc[1] - acc[0], 32'd3);
        check("b2b_gap2", acc[2] - acc[1], 32'd4);
        check("b2b_mem8", mem[8], 32'h00220001);
        check("b2b_mem9", mem[9], 32'hAABB3344);
`ifdef MEM_PERF_CNT_EN
        check("cnt_store", cnt_store, 32'd3);
        check("cnt_rmw", cnt_rmw, 32'd2);
        check("cnt_load", cnt_load, 32'd1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
